timer_counter: RTL

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with an interrupt output.
//
// Register map (word offset addr[1:0], i.e. byte offset bits [3:2]):
//   0 CTRL   [3]=IM irq mask, [2:1]=Mode, [0]=Enable, [31:4] read as 0
//   1 PRESET reload value
//   2 COUNT  current count, read-only
//   3 reads 0, writes ignored
//
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset
//   addr  - word address addr[31:2] from the bridge; only addr[1:0] decoded
//   we    - write strobe, asserted only when this device is selected
//   din   - write data
//   dout  - combinational read data for the addressed register
//   irq   - interrupt request, IM & irq_flag
//
// Build option: define TIMER_COUNTER_MODE1_EN to enable Mode=1 auto-reload.
// Without it Mode=1 behaves like Mode=0 (the Mode field is still stored).
//
// state | meaning
// IDLE  | waiting for Enable, COUNT held
// LOAD  | COUNT <= PRESET
// CNT   | counting down, stops to IDLE when Enable drops
// INT   | terminal count reached, irq_flag set

module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_nxt;
    logic        en, im;
    logic [1:0]  mode;
    logic [31:0] preset, count, count_nxt;
    logic        irq_flag;
    logic        flag_set, flag_clr_fsm, en_clr;
    logic        reload_mode;
    logic        ctrl_wr, preset_wr;

    logic unused_addr;
    assign unused_addr = ^addr[29:2];

`ifdef TIMER_COUNTER_MODE1_EN
    assign reload_mode = (mode == 2'd1);
`else
    assign reload_mode = 1'b0;
`endif

    assign ctrl_wr   = we && (addr[1:0] == 2'd0);
    assign preset_wr = we && (addr[1:0] == 2'd1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        flag_set     = 1'b0;
        flag_clr_fsm = 1'b0;
        en_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = LOAD;
            end
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // PRESET of 0 or 1 also lands here and still raises irq
                    count_nxt = 32'd0;
                    flag_set  = 1'b1;
                    state_nxt = INT;
                end
            end
            INT: begin
                state_nxt = IDLE;
                if (reload_mode) flag_clr_fsm = 1'b1;
                else             en_clr       = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // CPU writes to CTRL take priority over FSM updates of Enable and irq_flag
    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b0;
            mode     <= 2'd0;
            im       <= 1'b0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            count <= count_nxt;
            if (preset_wr) preset <= din;
            if (ctrl_wr) begin
                en   <= din[0];
                mode <= din[2:1];
                im   <= din[3];
            end else if (en_clr) begin
                en <= 1'b0;
            end
            if (ctrl_wr)           irq_flag <= 1'b0;
            else if (flag_set)     irq_flag <= 1'b1;
            else if (flag_clr_fsm) irq_flag <= 1'b0;
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr[1:0])
            2'd0:    dout = {28'd0, im, mode, en};
            2'd1:    dout = preset;
            2'd2:    dout = count;
            default: dout = 32'd0;
        endcase
    end

    assign irq = im & irq_flag;

endmodule
